// File: rtl/stack_arb_pkg.sv
// Stack arbiter shared definitions.
// Op encoding, FSM states and stack geometry.
package stack_arb_pkg;

    localparam int NUM_STACKS = 8;
    localparam int SEL_W      = 3;
    localparam int OFF_W      = 6;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        OP_PUSH   = 2'd0,
        OP_POP    = 2'd1,
        OP_IDX_RD = 2'd2,
        OP_IDX_WR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/stack_arbiter_rr.sv
// Round-robin grant for the stack arbiter.
// Requester after the last winner has top priority.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [IW-1:0] win;
    logic [IW-1:0] jj;
    logic          found;
    int            j;

    // Scan requesters starting at the pointer, first one set wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        win     = ptr_q;
        j       = 0;
        jj      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IW'(j);
            if (!found && req_i[jj]) begin
                found       = 1'b1;
                grant_o[jj] = 1'b1;
                win         = jj;
            end
        end
    end

    // Next priority starts just after the winner.
    always_comb begin
        if (win == IW'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = win + IW'(1);
        end
    end

    // Move the pointer only when a grant is taken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (advance_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Arbitrates NUM_REQ requesters onto one stack unit.
// Each op takes IDLE->ISSUE->EXEC->RESP, four cycles.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    input  logic [2*NUM_REQ-1:0]    req_op_i,
    input  logic [3*NUM_REQ-1:0]    req_sel_i,
    input  logic [6*NUM_REQ-1:0]    req_offset_i,
    input  logic [32*NUM_REQ-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    output logic [NUM_REQ-1:0]      rsp_valid_o,
    output logic [31:0]             rsp_data_o,
    output logic                    rsp_err_o,
    output logic [NUM_REQ-1:0]      err_sticky_o,
    input  logic [NUM_REQ-1:0]      err_clr_i,
    output logic [2:0]              stk_select_o,
    output logic                    stk_push_o,
    output logic                    stk_pop_o,
    output logic                    stk_index_read_o,
    output logic                    stk_index_write_o,
    output logic [5:0]              stk_offset_o,
    output logic [31:0]             stk_data_o,
    input  logic [31:0]             stk_data_i,
    input  logic                    stk_ready_i,
    input  logic                    stk_overflow_i,
    input  logic                    stk_underflow_i
);

    state_e              state_q;
    op_e                 op_q;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [NUM_REQ-1:0]  rsp_vld_q;
    logic [NUM_REQ-1:0]  err_q;
    logic [NUM_REQ-1:0]  err_d;
    logic                accept;
    logic                stk_err;
    logic                push_q;
    logic                pop_q;
    logic                rd_q;
    logic                wr_q;
    logic [1:0]          op_mux;
    logic [SEL_W-1:0]    sel_mux;
    logic [SEL_W-1:0]    sel_q;
    logic [OFF_W-1:0]    off_mux;
    logic [OFF_W-1:0]    off_q;
    logic [DATA_W-1:0]   wdata_mux;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   data_q;

    assign accept = rst_ni & (state_q == ST_IDLE) & stk_ready_i
                  & (|req_valid_i);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_valid_i),
        .advance_i (accept),
        .grant_o   (grant)
    );

    // One-hot select of the winning requester's fields.
    always_comb begin
        op_mux    = '0;
        sel_mux   = '0;
        off_mux   = '0;
        wdata_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_mux    = req_op_i[2*i +: 2];
                sel_mux   = req_sel_i[3*i +: 3];
                off_mux   = req_offset_i[6*i +: 6];
                wdata_mux = req_wdata_i[32*i +: 32];
            end
        end
    end

    assign stk_err = stk_overflow_i | stk_underflow_i;

    // Sticky error: clear wins over a same-cycle set.
    always_comb begin
        err_d = err_q;
        if (state_q == ST_RESP && stk_err) begin
            err_d = err_d | gnt_q;
        end
        err_d = err_d & ~err_clr_i;
    end

    // Operation sequencer with registered stack-side outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_PUSH;
            gnt_q     <= '0;
            rsp_vld_q <= '0;
            err_q     <= '0;
            push_q    <= 1'b0;
            pop_q     <= 1'b0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            sel_q     <= '0;
            off_q     <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
        end else begin
            err_q <= err_d;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q <= ST_ISSUE;
                        op_q    <= op_e'(op_mux);
                        gnt_q   <= grant;
                        sel_q   <= sel_mux;
                        off_q   <= off_mux;
                        wdata_q <= wdata_mux;
                        push_q  <= (op_e'(op_mux) == OP_PUSH);
                        pop_q   <= (op_e'(op_mux) == OP_POP);
                        rd_q    <= (op_e'(op_mux) == OP_IDX_RD);
                        wr_q    <= (op_e'(op_mux) == OP_IDX_WR);
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_EXEC;
                    push_q  <= 1'b0;
                    pop_q   <= 1'b0;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                end
                ST_EXEC: begin
                    state_q   <= ST_RESP;
                    rsp_vld_q <= gnt_q;
                    sel_q     <= '0;
                    off_q     <= '0;
                    wdata_q   <= '0;
                    if (op_q == OP_POP || op_q == OP_IDX_RD) begin
                        data_q <= stk_data_i;
                    end else begin
                        data_q <= '0;
                    end
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    rsp_vld_q <= '0;
                    gnt_q     <= '0;
                    data_q    <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o       = grant & {NUM_REQ{accept}};
    assign rsp_valid_o       = rsp_vld_q;
    assign rsp_data_o        = data_q;
    assign rsp_err_o         = (state_q == ST_RESP) & stk_err;
    assign err_sticky_o      = err_q;
    assign stk_select_o      = sel_q;
    assign stk_offset_o      = off_q;
    assign stk_data_o        = wdata_q;
    assign stk_push_o        = push_q;
    assign stk_pop_o         = pop_q;
    assign stk_index_read_o  = rd_q;
    assign stk_index_write_o = wr_q;

endmodule
